alu_issue_ctrl: RTL

Issue-side controller that drives the ALU datapath. It accepts 32-bit MIPS instruction words with their register operands over a valid/ready handshake, decodes them into ALUop/funct codes, and drives registered operands into the datapath. It sequences the multi-cycle unsigned multiply and returns write-back results over a second valid/ready handshake. It sits between the decode/register-read stage and the ALU datapath's `ALUop`/`Signal`/`dataA`/`dataB`/`Output` ports.

---
 rtl/alu_issue_ctrl_pkg.sv | 57 +++++
 rtl/alu_issue_ctrl_if.sv | 34 +++
 rtl/alu_issue_ctrl_funct_decode.sv | 63 ++++++
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_pkg: MIPS opcode/funct codes, ALUop encodings, decode record and FSM
// states shared by the ALU issue controller and its decoder.
package alu_issue_pkg;

    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_ADDI  = 6'd8;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_A_ZERO = 2'd0,
        SEL_A_RS   = 2'd1,
        SEL_A_RT   = 2'd2
    } sel_a_t;

    typedef enum logic [1:0] {
        SEL_B_ZERO = 2'd0,
        SEL_B_RT   = 2'd1,
        SEL_B_IMM  = 2'd2
    } sel_b_t;

    // imm carries either the zero-extended shamt (SRL) or the sign-extended immediate (ADDI)
    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  signal;
        sel_a_t      sel_a;
        sel_b_t      sel_b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        is_mult;
        logic        is_wb;
        logic        is_illegal;
    } decode_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_if: instruction, datapath and write-back signals of the ALU issue controller.
// The master modport is the controller's view; slave is the surrounding pipeline/datapath.
interface alu_issue_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic [1:0]  alu_op;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_result;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;

    modport master (
        input  instr_valid, instr, rs_data, rt_data, alu_result, res_ready,
        output instr_ready, alu_op, alu_signal, alu_dataA, alu_dataB,
               res_valid, res_data, res_rd
    );

    modport slave (
        output instr_valid, instr, rs_data, rt_data, alu_result, res_ready,
        input  instr_ready, alu_op, alu_signal, alu_dataA, alu_dataB,
               res_valid, res_data, res_rd
    );

endinterface

// File: rtl/alu_issue_ctrl_funct_decode.sv
// alu_funct_decode: purely combinational MIPS instruction decoder producing ALUop,
// funct code, operand selects, destination register and instruction class.
module alu_funct_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    // The rs field is not needed here; rs_data already arrives as a register value.
    logic unused_rs;
    assign unused_rs = ^instr[25:21];

    always_comb begin
        dec            = '0;
        dec.sel_a      = SEL_A_ZERO;
        dec.sel_b      = SEL_B_ZERO;
        dec.is_illegal = 1'b0;

        case (instr[31:26])
            OPC_RTYPE: begin
                dec.op     = ALUOP_RTYPE;
                dec.signal = instr[5:0];
                case (instr[5:0])
                    FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: begin
                        dec.sel_a = SEL_A_RS;
                        dec.sel_b = SEL_B_RT;
                        dec.rd    = instr[15:11];
                        dec.is_wb = 1'b1;
                    end
                    FN_SRL: begin
                        dec.sel_a = SEL_A_RT;
                        dec.sel_b = SEL_B_IMM;
                        dec.imm   = {27'd0, instr[10:6]};
                        dec.rd    = instr[15:11];
                        dec.is_wb = 1'b1;
                    end
                    FN_MULTU: begin
                        dec.sel_a   = SEL_A_RS;
                        dec.sel_b   = SEL_B_RT;
                        dec.is_mult = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec.rd    = instr[15:11];
                        dec.is_wb = 1'b1;
                    end
                    default: dec.is_illegal = 1'b1;
                endcase
            end
            OPC_ADDI: begin
                dec.op     = ALUOP_ADD;
                dec.signal = FN_ADD;
                dec.sel_a  = SEL_A_RS;
                dec.sel_b  = SEL_B_IMM;
                dec.imm    = sign_ext16(instr[15:0]);
                dec.rd     = instr[20:16];
                dec.is_wb  = 1'b1;
            end
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues decoded MIPS ALU instructions to the datapath, sequences MULTU
// and returns write-back results. Optional sticky 'illegal' flag: ALU_ISSUE_ILLEGAL_EN.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int MULT_CYCLES = 32,
    parameter int RESULT_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.master bus
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    localparam int MAX_CNT = (MULT_CYCLES > RESULT_LAT) ? MULT_CYCLES : RESULT_LAT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ready_q;
    decode_t       dec;
    logic [31:0]   opa, opb;
    logic          accept, issue, capture;

    logic [1:0]    alu_op_q;
    logic [5:0]    alu_signal_q;
    logic [31:0]   data_a_q, data_b_q;
    logic [31:0]   res_data_q;
    logic [4:0]    res_rd_q;

    alu_funct_decode u_decode (
        .instr (bus.instr),
        .dec   (dec)
    );

    assign accept  = bus.instr_valid && ready_q;
    assign issue   = accept && !dec.is_illegal && (dec.is_mult || dec.is_wb);
    assign capture = (state == EXEC) && (cnt == '0);

    always_comb begin
        opa = '0;
        opb = '0;
        case (dec.sel_a)
            SEL_A_RS: opa = bus.rs_data;
            SEL_A_RT: opa = bus.rt_data;
            default:  opa = '0;
        endcase
        case (dec.sel_b)
            SEL_B_RT:  opb = bus.rt_data;
            SEL_B_IMM: opb = dec.imm;
            default:   opb = '0;
        endcase
    end

    // One counter serves both the result latency in EXEC and the multiplier wait in MULT
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (issue) begin
                    if (dec.is_mult) begin
                        state_n = MULT;
                        cnt_n   = CW'(MULT_CYCLES);
                    end else begin
                        state_n = EXEC;
                        cnt_n   = CW'(RESULT_LAT);
                    end
                end
            end
            EXEC: begin
                if (cnt == '0) state_n = DONE;
                else           cnt_n   = cnt - CW'(1);
            end
            MULT: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            DONE: begin
                if (bus.res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= (state_n == IDLE);
        end
    end

    // Datapath inputs only change on an issue, so they hold steady while idle or multiplying
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op_q     <= '0;
            alu_signal_q <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            res_rd_q     <= '0;
            res_data_q   <= '0;
        end else begin
            if (issue) begin
                alu_op_q     <= dec.op;
                alu_signal_q <= dec.signal;
                data_a_q     <= opa;
                data_b_q     <= opb;
                res_rd_q     <= dec.rd;
            end
            if (capture) begin
                res_data_q <= bus.alu_result;
            end
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else if (accept && dec.is_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`endif

    assign bus.instr_ready = ready_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_signal  = alu_signal_q;
    assign bus.alu_dataA   = data_a_q;
    assign bus.alu_dataB   = data_b_q;
    assign bus.res_valid   = (state == DONE);
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;

endmodule
